btn_debounce: RTL and testbench
===============================

// Module: btn_debounce
// PURPOSE
//   Conditions a raw push-button pin into a clean level plus single-cycle edge pulses.
//   It is the producer side of the toggle-LED path: rise drives the d/toggle input of the LED toggle flop.
//   It sits directly behind the icestick pin, in the single 12 MHz clk domain.
// PARAMETERS
//   STABLE_CYCLES  120_000  consecutive synced samples required to accept a change (10 ms @ 12 MHz); must be >= 2
//   ACTIVE_LOW     0        1 = pin reads 0 when pressed; btn is inverted before the synchronizer
// PORTS
//   clk    in   1  system clock, all logic on rising edge
//   rst    in   1  asynchronous, active-high reset
//   btn    in   1  raw, asynchronous, bouncing button pin
//   level  out  1  debounced pressed state (1 = pressed)
//   rise   out  1  one-cycle pulse on accepted press; drives the toggle input
//   fall   out  1  one-cycle pulse on accepted release
//   busy   out  1  1 while a candidate change is being qualified (PEND_* states)
// BEHAVIOUR
//   - Reset (async assert, sync release): sync flops=0 (post-inversion, i.e. released), state=REL,
//     cnt=0, level=0, rise=0, fall=0, busy=0. All outputs are registered.
//   - Synchronizer: b = btn ^ ACTIVE_LOW -> s1 -> s (2 flops). FSM uses only s.
//   - cnt width = $clog2(STABLE_CYCLES); it never wraps past STABLE_CYCLES-1.
//   - FSM states: REL, PEND_P, PRESS, PEND_R.
//     REL:    s=1 -> PEND_P, cnt<=0; else stay.
//     PEND_P: s=0 -> REL, cnt<=0 (glitch rejected, no pulse).
//             s=1 and cnt<STABLE_CYCLES-1 -> cnt++.
//             s=1 and cnt==STABLE_CYCLES-1 -> PRESS, level<=1, rise<=1.
//     PRESS:  s=0 -> PEND_R, cnt<=0; else stay.
//     PEND_R: mirror of PEND_P (s=1 -> PRESS; commit -> REL, level<=0, fall<=1).
//   - rise/fall are high for exactly one cycle, asserted on the same edge that level changes.
//     rise and fall are never high together.
//   - busy = (state==PEND_P || state==PEND_R), registered alongside the state.
//   - Latency: take edge 1 as the first edge at which btn is sampled at its new value.
//     level/rise update on edge STABLE_CYCLES+3, provided s holds the new value on
//     edges 3..STABLE_CYCLES+3.
//   - Any reversion of s during PEND restarts qualification from scratch.
//     No partial credit is kept between attempts.
//   - A bounce while in PRESS/REL only enters PEND; level is unaffected until commit.
//   - Reset mid-PEND or mid-PRESS: pending change is abandoned and outputs go to 0 immediately.
//     No fall pulse is generated by reset.
//   - If btn is still pressed after reset release, it is qualified as a new press (rise after STABLE_CYCLES+3 edges).
// TESTING (bench uses STABLE_CYCLES=4, 2 ns clk period)
//   1 Reset: rst=1 for 5 cycles, btn=1 -> level/rise/fall/busy=0 throughout;
//     after release, rise pulses on edge 7 and level=1.
//   2 Clean press/release: btn 0->1 held 20 cycles, then ->0 -> level=1 at edge 7 with one rise cycle;
//     level=0 seven edges after release with one fall cycle.
//   3 Glitch: btn=1 for 3 cycles, then 0 -> busy goes high then low; level, rise and fall stay 0.
//   4 Bounce: btn toggles every cycle for 10 cycles, then held 1 -> exactly one rise,
//     on edge 7 counted from the last transition.
//   5 Reset mid-qualification: assert rst while busy=1 in PEND_P -> outputs 0 asynchronously,
//     no pulse; btn still 1 after release -> rise 7 edges later.
//   6 ACTIVE_LOW=1 instance: btn idles 1, goes 0 -> level=1 with one rise pulse on edge 7;
//     checker asserts rise&fall never both 1.

Source files
------------

// File: rtl/btn_debounce.sv
// Push-button conditioner: a two-flop synchronizer and a four-state qualification FSM.
// It produces a debounced level plus single-cycle rise/fall pulses, all from registers.
`timescale 1ns/1ps
module btn_debounce #(
  parameter int STABLE_CYCLES = 120_000,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [1:0] ST_REL    = 2'd0;
  localparam logic [1:0] ST_PEND_P = 2'd1;
  localparam logic [1:0] ST_PRESS  = 2'd2;
  localparam logic [1:0] ST_PEND_R = 2'd3;

  logic             btn_in;
  logic [1:0]       sync_reg;
  logic             s;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;
  logic             busy_reg, busy_next;

  // Polarity is normalised before synchronizing, so 1 always means pressed.
  assign btn_in = btn ^ ACTIVE_LOW;
  assign s      = sync_reg[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], btn_in};
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    level_next = level_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      ST_REL: begin
        if (s) begin
          state_next = ST_PEND_P;
          cnt_next   = '0;
        end
      end
      ST_PEND_P: begin
        if (!s) begin
          state_next = ST_REL;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = ST_PRESS;
          cnt_next   = '0;
          level_next = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_PRESS: begin
        if (!s) begin
          state_next = ST_PEND_R;
          cnt_next   = '0;
        end
      end
      ST_PEND_R: begin
        if (s) begin
          state_next = ST_PRESS;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = ST_REL;
          cnt_next   = '0;
          level_next = 1'b0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_REL;
        cnt_next   = '0;
        level_next = 1'b0;
      end
    endcase
    // busy tracks the state being entered so it stays aligned with state_reg.
    busy_next = (state_next == ST_PEND_P) || (state_next == ST_PEND_R);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_REL;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
      busy_reg  <= busy_next;
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: expected pulses (kind + cycle) are queued when the
// button is driven and matched against every rise/fall pulse the two instances emit.
`timescale 1ns/1ps
module tb_btn_debounce;

  localparam int SC  = 4;
  localparam int LAT = SC + 3;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic btn0 = 1'b1;
  logic btn1 = 1'b1;
  logic level0, rise0, fall0, busy0;
  logic level1, rise1, fall1, busy1;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit is_rise;
    int cyc;
  } ev_t;

  ev_t exp0[$];
  ev_t exp1[$];

  btn_debounce #(.STABLE_CYCLES(SC), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst(rst), .btn(btn0),
    .level(level0), .rise(rise0), .fall(fall0), .busy(busy0)
  );

  btn_debounce #(.STABLE_CYCLES(SC), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst(rst), .btn(btn1),
    .level(level1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  always #1 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #0.5;
    end
  endtask

  task automatic push0(input bit is_rise);
    ev_t e;
    e.is_rise = is_rise;
    e.cyc     = cyc + LAT;
    exp0.push_back(e);
  endtask

  task automatic push1(input bit is_rise);
    ev_t e;
    e.is_rise = is_rise;
    e.cyc     = cyc + LAT;
    exp1.push_back(e);
  endtask

  task automatic check_quiet0(input string tag);
    check({tag, "_level"}, level0, 0);
    check({tag, "_rise"},  rise0,  0);
    check({tag, "_fall"},  fall0,  0);
    check({tag, "_busy"},  busy0,  0);
  endtask

  // Monitor for the active-high instance.
  always @(negedge clk) begin
    ev_t e;
    check("excl0", rise0 & fall0, 0);
    if (rise0 || fall0) begin
      if (exp0.size() == 0) begin
        check("unexpected_pulse0", {rise0, fall0}, 0);
      end else begin
        e = exp0.pop_front();
        check("kind0",  rise0,  e.is_rise);
        check("cycle0", cyc,    e.cyc);
        check("level0", level0, e.is_rise);
        $display("dut0 %s pulse at cycle %0d (expected %0d)", rise0 ? "rise" : "fall", cyc, e.cyc);
      end
    end
  end

  // Monitor for the active-low instance.
  always @(negedge clk) begin
    ev_t e;
    check("excl1", rise1 & fall1, 0);
    if (rise1 || fall1) begin
      if (exp1.size() == 0) begin
        check("unexpected_pulse1", {rise1, fall1}, 0);
      end else begin
        e = exp1.pop_front();
        check("kind1",  rise1,  e.is_rise);
        check("cycle1", cyc,    e.cyc);
        check("level1", level1, e.is_rise);
        $display("dut1 %s pulse at cycle %0d (expected %0d)", rise1 ? "rise" : "fall", cyc, e.cyc);
      end
    end
  end

  initial begin
    // 1: reset with the button held, then qualification after release
    repeat (5) begin
      step(1);
      check_quiet0("t1_rst");
    end
    rst = 1'b0;
    push0(1'b1);
    step(LAT + 3);
    check("t1_level", level0, 1);
    check("t1_level1_idle", level1, 0);

    // 2: clean release, press held 20 cycles, release
    btn0 = 1'b0;
    push0(1'b0);
    step(LAT + 3);
    check("t2_level_rel", level0, 0);
    btn0 = 1'b1;
    push0(1'b1);
    step(20);
    check("t2_level_hold", level0, 1);
    btn0 = 1'b0;
    push0(1'b0);
    step(LAT + 3);
    check("t2_level_end", level0, 0);
    check("t2_queue", exp0.size(), 0);

    // 3: short glitch is rejected
    btn0 = 1'b1;
    step(3);
    check("t3_busy_hi", busy0, 1);
    btn0 = 1'b0;
    step(LAT + 3);
    check("t3_busy_lo", busy0, 0);
    check("t3_level", level0, 0);

    // 4: bounce then settle pressed, then release
    for (int i = 0; i < 10; i++) begin
      btn0 = ~btn0;
      step(1);
    end
    btn0 = 1'b1;
    push0(1'b1);
    step(LAT + 3);
    check("t4_level", level0, 1);
    btn0 = 1'b0;
    push0(1'b0);
    step(LAT + 3);
    check("t4_level_end", level0, 0);

    // 5: reset in PEND_P, then reset in PRESS
    btn0 = 1'b1;
    step(4);
    check("t5_busy", busy0, 1);
    rst = 1'b1;
    #0.1;
    check_quiet0("t5_async");
    step(2);
    check_quiet0("t5_held");
    rst = 1'b0;
    push0(1'b1);
    step(LAT + 3);
    check("t5_level", level0, 1);
    rst = 1'b1;
    #0.1;
    check_quiet0("t5_press_rst");
    step(2);
    rst = 1'b0;
    push0(1'b1);
    step(LAT + 3);
    check("t5_level_again", level0, 1);
    btn0 = 1'b0;
    push0(1'b0);
    step(LAT + 3);
    check("t5_level_end", level0, 0);

    // 6: active-low instance
    check("t6_idle", level1, 0);
    btn1 = 1'b0;
    push1(1'b1);
    step(LAT + 3);
    check("t6_level", level1, 1);
    btn1 = 1'b1;
    push1(1'b0);
    step(LAT + 3);
    check("t6_level_end", level1, 0);

    check("final_queue0", exp0.size(), 0);
    check("final_queue1", exp1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
